// File: rtl/ysyx_22050598_ifu.sv
// rtl/ysyx_22050598_ifu.sv - instruction fetch unit: PC owner, single-outstanding imem fetch, one-entry decode buffer
// Optional perf counters enabled by defining YSYX_22050598_IFU_PERF_EN.
module ysyx_22050598_ifu #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
`ifdef YSYX_22050598_IFU_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;
    logic            inst_fault_q, inst_fault_d;

    logic req_fire;
    logic rsp_pending;
    logic inst_fire;

    // A misaligned pc (left by a misaligned redirect) parks fetch until the next redirect.
    assign imem_req_valid = rst_n & (state_q == S_REQ) & ~kill_q & (pc_q[1:0] == 2'b00);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_pending    = (state_q == S_WAIT) | kill_q;
    assign inst_fire      = inst_valid_q & inst_ready;

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;

        if (redirect_valid) begin
            pc_d         = redirect_pc;
            inst_valid_d = 1'b0;
            inst_d       = 32'h0;
            inst_pc_d    = '0;
            inst_fault_d = 1'b0;
            // kill marks exactly one response still owed by memory that must be dropped
            kill_d       = req_fire | (rsp_pending & ~imem_rsp_valid);
            if (redirect_pc[1:0] != 2'b00) begin
                state_d      = S_HOLD;
                inst_valid_d = 1'b1;
                inst_pc_d    = redirect_pc;
                inst_fault_d = 1'b1;
            end else begin
                state_d = kill_d ? S_WAIT : S_REQ;
            end
        end else begin
            if (kill_q && imem_rsp_valid) begin
                kill_d = 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            state_d = S_REQ;
                        end else begin
                            inst_valid_d = 1'b1;
                            inst_d       = imem_rsp_err ? 32'h0 : imem_rsp_data;
                            inst_pc_d    = pc_q;
                            inst_fault_d = imem_rsp_err;
                            pc_d         = pc_q + PC_W'(4);
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_fire) begin
                        inst_valid_d = 1'b0;
                        inst_d       = 32'h0;
                        inst_pc_d    = '0;
                        inst_fault_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

`ifdef YSYX_22050598_IFU_PERF_EN
    logic [63:0] perf_fetch_q, perf_fetch_d;
    logic [63:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (inst_fire && !redirect_valid) begin
            perf_fetch_d = perf_fetch_q + 64'd1;
        end
        if (inst_valid_q && !inst_ready) begin
            perf_stall_d = perf_stall_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= 64'd0;
            perf_stall_q <= 64'd0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22050598_ifu.sv
// tb/tb_ysyx_22050598_ifu.sv - self-checking bench for ysyx_22050598_ifu against a transaction-level model
module tb_ysyx_22050598_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef YSYX_22050598_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ysyx_22050598_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef YSYX_22050598_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: decode-side expectation queue plus a one-slot memory
    exp_t        exp_q[$];
    logic [63:0] exp_pc;
    logic [63:0] m_fetch, m_stall;
    bit          mem_busy, mem_drop, mem_err;
    logic [63:0] mem_addr;
    int          mem_cnt;
    int          lat_fixed;
    bit          fixed_data, rand_err, prev_rst;
    logic [63:0] err_addr;
    int          cyc;

    logic [63:0] fire_addr_q[$];
    logic [63:0] hs_pc_q[$];
    logic [31:0] hs_inst_q[$];
    logic        hs_fault_q[$];
    int          hs_cyc_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        if (fixed_data) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic clear_logs();
        fire_addr_q.delete();
        hs_pc_q.delete();
        hs_inst_q.delete();
        hs_fault_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic step(input bit rst, input bit rdy, input bit irdy, input bit rv, input logic [63:0] rpc);
        bit   fire, hs;
        exp_t e;
        @(negedge clk);
        rst_n          = ~rst;
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = rv && !rst;
        redirect_pc    = rpc;
        if (!rst && mem_busy && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_addr);
            imem_rsp_err   = mem_err;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            imem_rsp_err   = 1'b0;
        end
        #1;
        if (rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            if (prev_rst) begin
                chk("rst_inst_valid", inst_valid, 0);
                chk("rst_inst", inst, 0);
                chk("rst_inst_pc", inst_pc, 0);
                chk("rst_inst_fault", inst_fault, 0);
            end
            mem_busy = 0;
            mem_drop = 0;
            exp_q.delete();
            exp_pc   = RST_PC;
            m_fetch  = 0;
            m_stall  = 0;
            prev_rst = 1;
            cyc      = 0;
            return;
        end
        prev_rst = 0;
`ifdef YSYX_22050598_IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
`endif
        chk("inst_valid", inst_valid, exp_q.size() != 0);
        if (inst_valid && exp_q.size() != 0) begin
            e = exp_q[0];
            chk("inst", inst, e.inst);
            chk("inst_pc", inst_pc, e.pc);
            chk("inst_fault", inst_fault, e.fault);
        end
        if (imem_req_valid) begin
            chk("req_addr", imem_req_addr, exp_pc);
            chk("req_outstanding", mem_busy, 0);
            chk("req_while_full", exp_q.size(), 0);
        end

        fire = imem_req_valid && rdy;
        hs   = inst_valid && irdy && !rv;
        if (exp_q.size() != 0 && !irdy) m_stall++;
        if (hs) begin
            m_fetch++;
            hs_pc_q.push_back(inst_pc);
            hs_inst_q.push_back(inst);
            hs_fault_q.push_back(inst_fault);
            hs_cyc_q.push_back(cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (imem_rsp_valid) begin
            if (!rv && !mem_drop) begin
                e.inst  = mem_err ? 32'h0 : mem_data(mem_addr);
                e.pc    = mem_addr;
                e.fault = mem_err;
                exp_q.push_back(e);
                exp_pc  = mem_addr + 64'd4;
            end
            mem_busy = 0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (fire) begin
            fire_addr_q.push_back(imem_req_addr);
            mem_busy = 1;
            mem_drop = 0;
            mem_addr = imem_req_addr;
            mem_cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            mem_err  = (imem_req_addr == err_addr) || (rand_err && $urandom_range(0, 7) == 0);
        end
        if (rv) begin
            if (mem_busy) mem_drop = 1;
            exp_q.delete();
            exp_pc = rpc;
            if (rpc[1:0] != 2'b00) begin
                e.inst  = 32'h0;
                e.pc    = rpc;
                e.fault = 1'b1;
                exp_q.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        clear_logs();
        repeat (3) step(1, 0, 0, 0, 64'h0);
    endtask

    initial begin
        logic [63:0] rpc;
        rst_n = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        imem_rsp_err = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
        lat_fixed = 0; fixed_data = 1; rand_err = 0; err_addr = 64'h0; prev_rst = 0;
        mem_busy = 0; mem_drop = 0; mem_err = 0; mem_addr = 0; mem_cnt = 0;
        exp_pc = RST_PC; m_fetch = 0; m_stall = 0; cyc = 0;

        // zero-wait memory, decode always ready
        do_reset();
        repeat (6) step(0, 1, 1, 0, 64'h0);
        chk("a_first_req", fire_addr_q.size() != 0 ? fire_addr_q[0] : 64'hx, 64'h8000_0000);
        chk("a_hs_count", hs_pc_q.size(), 2);
        if (hs_pc_q.size() >= 2) begin
            chk("a_hs_pc0", hs_pc_q[0], 64'h8000_0000);
            chk("a_hs_pc1", hs_pc_q[1], 64'h8000_0004);
            chk("a_hs_cyc0", hs_cyc_q[0], 2);
            chk("a_spacing", hs_cyc_q[1] - hs_cyc_q[0], 3);
            chk("a_inst", hs_inst_q[0], 32'h0000_0013);
        end

        // decode stalls for five cycles
        do_reset();
        repeat (7) step(0, 1, 0, 0, 64'h0);
        step(0, 1, 1, 0, 64'h0);
        chk("b_no_req_stall", fire_addr_q.size(), 1);
        chk("b_hs_cyc", hs_cyc_q.size() != 0 ? hs_cyc_q[0] : -1, 7);
`ifdef YSYX_22050598_IFU_PERF_EN
        @(negedge clk);
        chk("b_perf_stall5", perf_stall_cnt, 64'd5);
`endif

        // redirect while waiting on the response for 0x80000004
        lat_fixed = 1;
        do_reset();
        for (int i = 0; i < 14; i++) step(0, 1, 1, i == 5, 64'h8000_1000);
        chk("c_hs_count", hs_pc_q.size(), 2);
        chk("c_req_after_redir", fire_addr_q.size() >= 3 ? fire_addr_q[2] : 64'hx, 64'h8000_1000);
        chk("c_hs_pc", hs_pc_q.size() >= 2 ? hs_pc_q[1] : 64'hx, 64'h8000_1000);

        // access fault at 0x80000008
        lat_fixed = 0;
        err_addr  = 64'h8000_0008;
        do_reset();
        repeat (10) step(0, 1, 1, 0, 64'h0);
        chk("d_hs_count", hs_pc_q.size(), 3);
        if (hs_pc_q.size() >= 3) begin
            chk("d_fault_pc", hs_pc_q[2], 64'h8000_0008);
            chk("d_fault_inst", hs_inst_q[2], 32'h0);
            chk("d_fault_flag", hs_fault_q[2], 1);
            chk("d_ok_flag", hs_fault_q[1], 0);
        end
        err_addr = 64'h0;

        // misaligned redirect parks fetch until the next redirect
        do_reset();
        step(0, 1, 1, 1, 64'h8000_0002);
        repeat (6) step(0, 1, 1, 0, 64'h0);
        chk("e_fault_pc", hs_pc_q.size() != 0 ? hs_pc_q[0] : 64'hx, 64'h8000_0002);
        chk("e_fault_flag", hs_fault_q.size() != 0 ? hs_fault_q[0] : 1'bx, 1);
        chk("e_no_fetch", fire_addr_q.size(), 1);
        step(0, 1, 1, 1, 64'h8000_0100);
        repeat (4) step(0, 1, 1, 0, 64'h0);
        chk("e_resume", fire_addr_q.size() >= 2 ? fire_addr_q[1] : 64'hx, 64'h8000_0100);

        // reset asserted while waiting on memory
        do_reset();
        step(0, 1, 1, 0, 64'h0);
        step(1, 1, 1, 0, 64'h0);
        step(0, 1, 1, 0, 64'h0);
        chk("f_req_count", fire_addr_q.size(), 2);
        chk("f_req_addr", fire_addr_q.size() >= 2 ? fire_addr_q[1] : 64'hx, 64'h8000_0000);

        // randomized traffic
        lat_fixed  = -1;
        fixed_data = 0;
        rand_err   = 1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rpc = 64'h8000_0000 | 64'($urandom & 32'h0000_fffc);
            if ($urandom_range(0, 9) == 0) rpc = 64'hffff_ffff_ffff_fff8;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rpc);
            if (hs_pc_q.size() > 64) clear_logs();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
